// File: rtl/avl_arbiter_pkg.sv
// Shared definitions for the Avalon-MM master-port arbiters.
package avl_arbiter_pkg;

    // Arbiter FSM encoding: idle, or owning the bus on behalf of port D / port I
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_D = 2'd1,
        ST_OWN_I = 2'd2
    } arb_state_t;

    // Identity of the last owner, used for round-robin tie breaking
    localparam logic OWNER_D = 1'b0;
    localparam logic OWNER_I = 1'b1;

    // Width of the per-transfer wait-state counter
    localparam int WDOG_W = 8;

endpackage

// File: rtl/avl_arbiter_watchdog.sv
// Per-transfer bus watchdog: counts stalled cycles and flags an abort.
// o_expire is registered and is high in exactly the cycle the counter
// equals TIMEOUT, so the abort and the bus_err pulse line up in one cycle.
module avl_watchdog
    import avl_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [WDOG_W:0]   LP_TO  = (WDOG_W + 1)'(TIMEOUT);
    localparam logic [WDOG_W-1:0] LP_MAX = '1;

    logic [WDOG_W-1:0] r_count;
    logic              r_expire;
    logic [WDOG_W:0]   w_count_inc;

    assign w_count_inc = {1'b0, r_count} + 1'b1;
    assign o_expire    = r_expire;

    // Saturating stall counter; expire is pre-computed one cycle ahead
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count  <= '0;
            r_expire <= 1'b0;
        end else if (i_clear) begin
            r_count  <= '0;
            r_expire <= 1'b0;
        end else begin
            if (i_enable && (r_count != LP_MAX)) begin
                r_count <= r_count + 1'b1;
            end
            r_expire <= (TIMEOUT != 0) && i_enable && (w_count_inc == LP_TO);
        end
    end

endmodule

// File: rtl/avl_arbiter.sv
// Two-port round-robin arbiter for the core's single Avalon-MM master.
// Port D (data, read/write) and port I (instruction fetch, read only)
// share the bus one transaction at a time; bus signals are muxed
// combinationally so read data returns with no added latency.
module avl_arbiter
    import avl_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    // port D (data side)
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_writedata,
    input  logic [3:0]            d_byteenable,
    input  logic                  d_read,
    input  logic                  d_write,
    output logic [DATA_WIDTH-1:0] d_readdata,
    output logic                  d_waitrequest,
    // port I (instruction fetch)
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_read,
    output logic [DATA_WIDTH-1:0] i_readdata,
    output logic                  i_waitrequest,
    // shared bus
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] writedata,
    output logic [3:0]            byteenable,
    output logic                  read,
    output logic                  write,
    input  logic [DATA_WIDTH-1:0] readdata,
    input  logic                  waitrequest,
    output logic                  bus_err
);

    arb_state_t r_state;
    logic       r_last;

    logic w_req_d;
    logic w_req_i;
    logic w_own_d;
    logic w_own_i;
    logic w_strobe;
    logic w_expire;
    logic w_wd_clear;
    logic w_wd_enable;

    assign w_req_d = d_read | d_write;
    assign w_req_i = i_read;
    assign w_own_d = (r_state == ST_OWN_D);
    assign w_own_i = (r_state == ST_OWN_I);

    // Owner's strobe is what keeps the grant alive
    assign w_strobe = (w_own_d & w_req_d) | (w_own_i & w_req_i);

    // Counter restarts every idle cycle, so it is zero on entry to OWN_x
    assign w_wd_clear  = (r_state == ST_IDLE);
    assign w_wd_enable = (w_own_d | w_own_i) & waitrequest & w_strobe & ~w_expire;

    avl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_expire)
    );

    assign bus_err = w_expire;

    // Grant FSM: round-robin on contention, mandatory idle bubble after each transfer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_last  <= OWNER_I;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_d && w_req_i) begin
                        r_state <= (r_last == OWNER_I) ? ST_OWN_D : ST_OWN_I;
                    end else if (w_req_d) begin
                        r_state <= ST_OWN_D;
                    end else if (w_req_i) begin
                        r_state <= ST_OWN_I;
                    end
                end
                ST_OWN_D: begin
                    if (w_expire || (w_req_d && !waitrequest)) begin
                        r_state <= ST_IDLE;
                        r_last  <= OWNER_D;
                    end else if (!w_req_d) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OWN_I: begin
                    if (w_expire || (w_req_i && !waitrequest)) begin
                        r_state <= ST_IDLE;
                        r_last  <= OWNER_I;
                    end else if (!w_req_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus/requester mux: owner drives the bus, the other port is stalled
    always_comb begin
        address       = '0;
        writedata     = '0;
        byteenable    = 4'b0000;
        read          = 1'b0;
        write         = 1'b0;
        d_waitrequest = w_req_d;
        i_waitrequest = w_req_i;
        d_readdata    = readdata;
        i_readdata    = readdata;

        case (r_state)
            ST_OWN_D: begin
                address       = d_address;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                write         = d_write & ~w_expire;
                read          = d_read & ~d_write & ~w_expire;
                d_waitrequest = waitrequest & ~w_expire;
                i_waitrequest = 1'b1;
                if (w_expire) begin
                    d_readdata = '0;
                end
            end
            ST_OWN_I: begin
                address       = i_address;
                byteenable    = 4'b1111;
                read          = i_read & ~w_expire;
                i_waitrequest = waitrequest & ~w_expire;
                d_waitrequest = 1'b1;
                if (w_expire) begin
                    i_readdata = '0;
                end
            end
            default: begin
            end
        endcase

        if (!reset) begin
            d_waitrequest = 1'b1;
            i_waitrequest = 1'b1;
            d_readdata    = '0;
            i_readdata    = '0;
        end
    end

endmodule

// File: tb/tb_avl_arbiter.sv
// Directed bench for avl_arbiter (TIMEOUT = 4).
module tb_avl_arbiter;
    import avl_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_address, d_writedata, d_readdata;
    logic [3:0]  d_byteenable;
    logic        d_read, d_write, d_waitrequest;
    logic [31:0] i_address, i_readdata;
    logic        i_read, i_waitrequest;
    logic [31:0] address, writedata, readdata;
    logic [3:0]  byteenable;
    logic        read, write, waitrequest, bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    avl_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_byteenable  (d_byteenable),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_readdata    (d_readdata),
        .d_waitrequest (d_waitrequest),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_readdata    (i_readdata),
        .i_waitrequest (i_waitrequest),
        .address       (address),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .read          (read),
        .write         (write),
        .readdata      (readdata),
        .waitrequest   (waitrequest),
        .bus_err       (bus_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset        = 1'b0;
        d_address    = '0;
        d_writedata  = '0;
        d_byteenable = '0;
        d_read       = 1'b0;
        d_write      = 1'b0;
        i_address    = '0;
        i_read       = 1'b0;
        readdata     = '0;
        waitrequest  = 1'b0;

        // ---- reset held for 3 edges
        step();
        step();
        #1;
        chk("rst_read",   64'(read), 64'd0);
        chk("rst_write",  64'(write), 64'd0);
        chk("rst_dwait",  64'(d_waitrequest), 64'd1);
        chk("rst_iwait",  64'(i_waitrequest), 64'd1);
        chk("rst_buserr", 64'(bus_err), 64'd0);
        chk("rst_drdata", 64'(d_readdata), 64'd0);
        step();
        reset = 1'b1;
        #1;
        chk("idle_state", 64'(dut.r_state), 64'(ST_IDLE));
        chk("idle_dwait", 64'(d_waitrequest), 64'd0);
        chk("idle_iwait", 64'(i_waitrequest), 64'd0);

        // ---- single zero-wait D write
        step();
        d_write      = 1'b1;
        d_address    = 32'h100;
        d_writedata  = 32'hDEADBEEF;
        d_byteenable = 4'b1111;
        waitrequest  = 1'b0;
        #1;
        chk("wr_arb_write", 64'(write), 64'd0);
        chk("wr_arb_dwait", 64'(d_waitrequest), 64'd1);
        step();
        #1;
        chk("wr_write", 64'(write), 64'd1);
        chk("wr_read",  64'(read), 64'd0);
        chk("wr_addr",  64'(address), 64'h100);
        chk("wr_data",  64'(writedata), 64'hDEADBEEF);
        chk("wr_be",    64'(byteenable), 64'hF);
        chk("wr_dwait", 64'(d_waitrequest), 64'd0);
        chk("wr_iwait", 64'(i_waitrequest), 64'd1);
        step();
        d_write = 1'b0;
        #1;
        chk("wr_done_state", 64'(dut.r_state), 64'(ST_IDLE));
        chk("wr_done_write", 64'(write), 64'd0);

        // ---- contention from reset: D, I, D, I
        reset     = 1'b0;
        d_read    = 1'b1;
        d_address = 32'h200;
        i_read    = 1'b1;
        i_address = 32'h300;
        step();
        reset = 1'b1;
        #1;
        chk("ct_arb_read", 64'(read), 64'd0);
        chk("ct_arb_waits", 64'({d_waitrequest, i_waitrequest}), 64'b11);
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            chk("ct_grant_addr", 64'(address), (k % 2 == 0) ? 64'h200 : 64'h300);
            chk("ct_grant_read", 64'(read), 64'd1);
            chk("ct_grant_waits", 64'({d_waitrequest, i_waitrequest}),
                (k % 2 == 0) ? 64'b01 : 64'b10);
            step();
            #1;
            chk("ct_bubble_read", 64'(read), 64'd0);
        end

        // ---- I read with 3 wait states (last owner is I, D drops out)
        d_read      = 1'b0;
        i_address   = 32'h40;
        waitrequest = 1'b1;
        #1;
        chk("ws_idle_iwait", 64'(i_waitrequest), 64'd1);
        chk("ws_idle_dwait", 64'(d_waitrequest), 64'd0);
        for (int w = 0; w < 3; w++) begin
            step();
            #1;
            chk("ws_read",  64'(read), 64'd1);
            chk("ws_addr",  64'(address), 64'h40);
            chk("ws_be",    64'(byteenable), 64'hF);
            chk("ws_iwait", 64'(i_waitrequest), 64'd1);
        end
        step();
        waitrequest = 1'b0;
        readdata    = 32'h12345678;
        #1;
        chk("ws_done_iwait", 64'(i_waitrequest), 64'd0);
        chk("ws_done_rdata", 64'(i_readdata), 64'h12345678);
        chk("ws_done_read",  64'(read), 64'd1);
        step();
        i_read = 1'b0;
        #1;
        chk("ws_idle_state", 64'(dut.r_state), 64'(ST_IDLE));
        chk("ws_idle_err",   64'(bus_err), 64'd0);

        // ---- watchdog abort on D read, I pending behind it
        d_read      = 1'b1;
        d_address   = 32'h80;
        i_read      = 1'b1;
        i_address   = 32'h44;
        waitrequest = 1'b1;
        readdata    = 32'hCAFEF00D;
        for (int c = 1; c <= 4; c++) begin
            step();
            #1;
            chk("wd_pre_err",   64'(bus_err), 64'd0);
            chk("wd_pre_dwait", 64'(d_waitrequest), 64'd1);
            chk("wd_pre_read",  64'(read), 64'd1);
            chk("wd_pre_addr",  64'(address), 64'h80);
        end
        step();
        #1;
        chk("wd_err",    64'(bus_err), 64'd1);
        chk("wd_dwait",  64'(d_waitrequest), 64'd0);
        chk("wd_drdata", 64'(d_readdata), 64'd0);
        chk("wd_read",   64'(read), 64'd0);
        step();
        #1;
        chk("wd_after_err",   64'(bus_err), 64'd0);
        chk("wd_after_state", 64'(dut.r_state), 64'(ST_IDLE));
        step();
        #1;
        chk("wd_next_state", 64'(dut.r_state), 64'(ST_OWN_I));
        chk("wd_next_addr",  64'(address), 64'h44);
        chk("wd_next_iwait", 64'(i_waitrequest), 64'd1);

        // ---- reset during OWN_I with the bus stalled
        reset = 1'b0;
        step();
        #1;
        chk("mr_read",  64'(read), 64'd0);
        chk("mr_state", 64'(dut.r_state), 64'(ST_IDLE));
        chk("mr_err",   64'(bus_err), 64'd0);
        reset       = 1'b1;
        waitrequest = 1'b0;
        step();
        #1;
        chk("mr_regrant_state", 64'(dut.r_state), 64'(ST_OWN_D));
        chk("mr_regrant_addr",  64'(address), 64'h80);
        chk("mr_regrant_dwait", 64'(d_waitrequest), 64'd0);

        // ---- read and write together are treated as a write
        step();
        i_read  = 1'b0;
        d_write = 1'b1;
        step();
        #1;
        chk("rw_write", 64'(write), 64'd1);
        chk("rw_read",  64'(read), 64'd0);
        step();
        d_read  = 1'b0;
        d_write = 1'b0;
        #1;
        chk("rw_done_state", 64'(dut.r_state), 64'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/avl_arbiter.md
# avl_arbiter

Two-requester arbiter sharing the core's single Avalon-MM master port between the data-side bridge (port D) and the instruction-fetch bridge (port I). It sits between the core-side Avalon adapters and the system interconnect. It grants one transaction at a time with round-robin fairness, routes signals through a mux, and returns `waitrequest` to each requester. A watchdog aborts bus transfers that never complete.

## Interface
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 32, address width
- `TIMEOUT`, 255, max bus-wait cycles per transfer before abort; 0 disables the watchdog
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `d_address` / `i_address`  in  ADDR_WIDTH  requester address
- `d_writedata`  in  DATA_WIDTH  port D write data (port I is read-only)
- `d_byteenable`  in  4  port D byte lanes
- `d_read`, `d_write` / `i_read`  in  1  requester strobes, held until own waitrequest low
- `d_readdata` / `i_readdata`  out  DATA_WIDTH  read return
- `d_waitrequest` / `i_waitrequest`  out  1  stall to requester
- `address`  out  ADDR_WIDTH  bus address
- `writedata`  out  DATA_WIDTH  bus write data
- `byteenable`  out  4  bus byte lanes; `4'b1111` when port I is granted
- `read`, `write`  out  1  bus strobes
- `readdata`  in  DATA_WIDTH  bus read data
- `waitrequest`  in  1  bus stall
- `bus_err`  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, OWN_D, OWN_I. State register `last` records the last owner (D or I).
- Request definitions:
  - `reqD = d_read | d_write`
  - `reqI = i_read`
  - If `d_read` and `d_write` are both high, treat it as a write.
- IDLE transitions:
  - Only `reqD`: go to OWN_D.
  - Only `reqI`: go to OWN_I.
  - Both: grant the port that is not `last`.
  - Neither: stay in IDLE.
- IDLE outputs: bus `read`/`write` are 0, and `address`/`writedata`/`byteenable` are 0.
- OWN_x outputs:
  - Bus signals are combinationally muxed from port x.
  - `x_waitrequest = waitrequest`.
  - The other port's waitrequest is 1.
  - Both `d_readdata` and `i_readdata` are driven from bus `readdata`. They are qualified only by the requester's own waitrequest.
- Completion: in OWN_x, bus `waitrequest == 0` with port x strobe high. Next state is IDLE, and `last <= x`.
- Requester drops its strobe in OWN_x (protocol violation): next state IDLE, bus strobes low that cycle, `last` unchanged, no error flagged.
- Watchdog:
  - 8-bit counter, cleared on entry to OWN_x, incremented each OWN cycle with `waitrequest == 1`.
  - When it reaches `TIMEOUT` (TIMEOUT ≠ 0) that cycle:
    - Force `x_waitrequest = 0` and `x_readdata = 0`.
    - Drive bus `read`/`write` low.
    - Pulse `bus_err`.
    - Next state IDLE, `last <= x`.
  - Counter saturates; TIMEOUT must be ≤ 255.
- Port I waitrequest in IDLE is 1 when `reqI` is high, else 0. Same rule for port D. Requesters never see completion without a grant.

## Timing
- Reset (`reset == 0` at an edge):
  - state IDLE, `last = I` (so D wins the first contention), watchdog counter 0.
  - Outputs while in reset: `read = write = 0`, `bus_err = 0`, `d_waitrequest = i_waitrequest = 1`, readdata outputs 0.
- Reset mid-transaction aborts the transfer without completion. Bus strobes drop in the cycle after the reset edge.
- Grant latency: request seen in IDLE at cycle n, bus strobe asserted in cycle n+1.
- Minimum transaction: 2 cycles (arbitrate, then zero-wait transfer).
- Mandatory one-cycle IDLE bubble between transfers; peak throughput is 1 transfer per 2 cycles.
- Both requesting continuously: grants alternate D, I, D, I…
- Abort: `bus_err` is high in exactly the cycle the counter equals `TIMEOUT`, i.e. the (TIMEOUT+1)-th cycle in OWN_x.
- The only registered state is the state, `last`, the counter, and `bus_err`. All mux paths are combinational, so `readdata` has zero added latency.

## Structure
- Shared core package: state encoding (IDLE/OWN_D/OWN_I) and `OWNER_D`/`OWNER_I` constants. The same constants are reused by the future 3-port arbiter.
- One natural sub-module: `avl_watchdog` (counter, compare against TIMEOUT, `expire` pulse, `clear`/`enable` inputs).
- The output mux stays in the top level.

## Test plan
- Reset then idle: `reset = 0` for 3 cycles.
  - During reset: `read = write = 0`, both waitrequests 1.
  - After release with no requests: state IDLE, `d_waitrequest = 0`.
- Single D write, `d_address = 0x100`, `d_writedata = 0xDEADBEEF`, `d_byteenable = 4'b1111`, bus waitrequest low immediately:
  - `write = 1` with those values in cycle 1.
  - `d_waitrequest = 0` in cycle 1, state IDLE in cycle 2.
- Contention: `reqD` and `reqI` asserted together from reset, bus zero-wait.
  - Grant order D, I, D, I; one transfer completes every 2 cycles.
  - Non-granted waitrequest stays 1.
- Wait states: I read of 0x40, bus waitrequest high 3 cycles, then low with `readdata = 0x12345678`.
  - `i_waitrequest` tracks the bus.
  - `i_readdata = 0x12345678` in the completion cycle.
- Watchdog, TIMEOUT = 4, D read, bus waitrequest stuck high:
  - `bus_err` pulses in the 5th OWN_D cycle, with `d_waitrequest = 0`, `d_readdata = 0`, `read = 0`.
  - I is served next.
- Reset mid-transfer: reset asserted during OWN_I with waitrequest high.
  - Next cycle: `read = 0`, state IDLE, no `bus_err`.
  - After release, D (pending) is granted first.
